// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states, requester
// indices and default widths.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  localparam int REQ_FETCH = 0;
  localparam int REQ_LSU   = 1;
  localparam int REQ_DBG   = 2;

  localparam int DEF_N_REQ       = 3;
  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_INIT_CYCLES = 2;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Circular priority picker: returns the first two set bits of a mask,
// scanning upward from a start index and wrapping at N.
module rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] start,
  output logic             found_0,
  output logic [IDX_W-1:0] idx_0,
  output logic             found_1,
  output logic [IDX_W-1:0] idx_1
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    found_0 = 1'b0;
    idx_0   = '0;
    found_1 = 1'b0;
    idx_1   = '0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = IDX_W'((int'(start) + k) % N);
      if (mask[pos]) begin
        if (!found_0) begin
          found_0 = 1'b1;
          idx_0   = pos;
        end else if (!found_1) begin
          found_1 = 1'b1;
          idx_1   = pos;
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing a 2-read/1-write memory among N_REQ requesters,
// with a power-on phase that holds the memory in reset while its image loads.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [N_REQ*DATA_WIDTH-1:0] rsp_data,
  output logic                        busy,
  output logic                        mem_rst,
  output logic [ADDR_WIDTH-1:0]       mem_r_addr_0,
  output logic [ADDR_WIDTH-1:0]       mem_r_addr_1,
  input  logic [DATA_WIDTH-1:0]       mem_r_data_0,
  input  logic [DATA_WIDTH-1:0]       mem_r_data_1,
  output logic [ADDR_WIDTH-1:0]       mem_w_addr,
  output logic [DATA_WIDTH-1:0]       mem_w_data,
  output logic                        mem_w_en
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  arb_state_e       state_q;
  logic [CNT_W-1:0] init_cnt_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic             run;

  logic [ADDR_WIDTH-1:0] addr_a  [N_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [N_REQ];

  logic [N_REQ-1:0] rd_mask;
  logic [N_REQ-1:0] wr_mask;
  logic             rd_found_0, rd_found_1, wr_found;
  logic [IDX_W-1:0] rd_idx_0, rd_idx_1, wr_idx;
  logic             wr_unused_found;
  logic [IDX_W-1:0] wr_unused_idx;

  logic [IDX_W-1:0] last_d;
  logic [IDX_W-1:0] rr_ptr_next;

  logic [N_REQ-1:0]      rsp_valid_p1;
  logic [DATA_WIDTH-1:0] rsp_data_p1 [N_REQ];

  // Scan distance of a requester from the current round-robin pointer.
  function automatic logic [IDX_W-1:0] scan_dist(input logic [IDX_W-1:0] idx,
                                                 input logic [IDX_W-1:0] ptr);
    return IDX_W'((int'(idx) - int'(ptr) + N_REQ) % N_REQ);
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign rsp_data[g*DATA_WIDTH +: DATA_WIDTH] = rsp_data_p1[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      if (init_cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
        state_q <= ST_RUN;
      end else begin
        init_cnt_q <= init_cnt_q + CNT_W'(1);
      end
    end
  end

  assign run     = (state_q == ST_RUN);
  assign busy    = !run;
  assign mem_rst = !run;

  // Grant stage: purely combinational from req and state, never from read data.
  assign rd_mask = run ? (req & ~req_we) : '0;
  assign wr_mask = run ? (req &  req_we) : '0;

  rr_picker #(.N(N_REQ), .IDX_W(IDX_W)) u_rd_pick (
    .mask    (rd_mask),
    .start   (rr_ptr_q),
    .found_0 (rd_found_0),
    .idx_0   (rd_idx_0),
    .found_1 (rd_found_1),
    .idx_1   (rd_idx_1)
  );

  rr_picker #(.N(N_REQ), .IDX_W(IDX_W)) u_wr_pick (
    .mask    (wr_mask),
    .start   (rr_ptr_q),
    .found_0 (wr_found),
    .idx_0   (wr_idx),
    .found_1 (wr_unused_found),
    .idx_1   (wr_unused_idx)
  );

  always_comb begin
    gnt = '0;
    if (wr_found)   gnt[wr_idx]   = 1'b1;
    if (rd_found_0) gnt[rd_idx_0] = 1'b1;
    if (rd_found_1) gnt[rd_idx_1] = 1'b1;
  end

  assign mem_r_addr_0 = rd_found_0 ? addr_a[rd_idx_0] : '0;
  assign mem_r_addr_1 = rd_found_1 ? addr_a[rd_idx_1] : '0;
  assign mem_w_en     = wr_found;
  assign mem_w_addr   = wr_found ? addr_a[wr_idx]  : '0;
  assign mem_w_data   = wr_found ? wdata_a[wr_idx] : '0;

  // The pointer moves past whichever grant sits furthest along the scan.
  always_comb begin
    last_d = '0;
    if (wr_found && scan_dist(wr_idx, rr_ptr_q) > last_d)
      last_d = scan_dist(wr_idx, rr_ptr_q);
    if (rd_found_0 && scan_dist(rd_idx_0, rr_ptr_q) > last_d)
      last_d = scan_dist(rd_idx_0, rr_ptr_q);
    if (rd_found_1 && scan_dist(rd_idx_1, rr_ptr_q) > last_d)
      last_d = scan_dist(rd_idx_1, rr_ptr_q);
    rr_ptr_next = IDX_W'((int'(rr_ptr_q) + int'(last_d) + 1) % N_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (|gnt) begin
      rr_ptr_q <= rr_ptr_next;
    end
  end

  // Response stage: read data captured at the grant edge, strobe lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_p1 <= '0;
      for (int i = 0; i < N_REQ; i++) rsp_data_p1[i] <= '0;
    end else begin
      rsp_valid_p1 <= '0;
      if (rd_found_0) begin
        rsp_valid_p1[rd_idx_0] <= 1'b1;
        rsp_data_p1[rd_idx_0]  <= mem_r_data_0;
      end
      if (rd_found_1) begin
        rsp_valid_p1[rd_idx_1] <= 1'b1;
        rsp_data_p1[rd_idx_1]  <= mem_r_data_1;
      end
    end
  end

  assign rsp_valid = rsp_valid_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a small 2R1W memory model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  req_we;
  logic [47:0] req_addr;
  logic [47:0] req_wdata;
  logic [2:0]  gnt;
  logic [2:0]  rsp_valid;
  logic [47:0] rsp_data;
  logic        busy;
  logic        mem_rst;
  logic [15:0] mem_r_addr_0, mem_r_addr_1;
  logic [15:0] mem_r_data_0, mem_r_data_1;
  logic [15:0] mem_w_addr, mem_w_data;
  logic        mem_w_en;

  mem_port_arbiter #(
    .N_REQ(3), .ADDR_WIDTH(16), .DATA_WIDTH(16), .INIT_CYCLES(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .mem_rst      (mem_rst),
    .mem_r_addr_0 (mem_r_addr_0),
    .mem_r_addr_1 (mem_r_addr_1),
    .mem_r_data_0 (mem_r_data_0),
    .mem_r_data_1 (mem_r_data_1),
    .mem_w_addr   (mem_w_addr),
    .mem_w_data   (mem_w_data),
    .mem_w_en     (mem_w_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: image loaded once during the first mem_rst, then kept across resets.
  logic [15:0] mem [256];
  bit          img_loaded;

  always @(posedge clk) begin
    if (mem_rst && !img_loaded) begin
      for (int a = 0; a < 256; a++) mem[a] <= 16'h0000;
      mem[8'h40] <= 16'h0003;
      mem[8'h41] <= 16'h0004;
      mem[8'h42] <= 16'h0001;
      img_loaded <= 1'b1;
    end else if (mem_w_en) begin
      mem[mem_w_addr[7:0]] <= mem_w_data;
    end
  end

  assign mem_r_data_0 = mem[mem_r_addr_0[7:0]];
  assign mem_r_data_1 = mem[mem_r_addr_1[7:0]];

  typedef struct {
    int          idx;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push_exp(input int idx, input logic [15:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every response strobe must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (rsp_valid[i]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: req=%0d data=%h, none expected", i, rsp_data[i*16 +: 16]);
          end else begin
            e = exp_q.pop_front();
            if (e.idx != i || rsp_data[i*16 +: 16] !== e.data) begin
              errors++;
              $display("FAIL rsp: got req=%0d data=%h want req=%0d data=%h",
                       i, rsp_data[i*16 +: 16], e.idx, e.data);
            end
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
    req[i]                 = 1'b1;
    req_we[i]              = we;
    req_addr[i*16 +: 16]   = a;
    req_wdata[i*16 +: 16]  = d;
  endtask

  logic [2:0] wr_gnt_tbl [4];

  initial begin
    wr_gnt_tbl[0] = 3'b010;
    wr_gnt_tbl[1] = 3'b100;
    wr_gnt_tbl[2] = 3'b010;
    wr_gnt_tbl[3] = 3'b100;

    rst_n     = 1'b0;
    req       = 3'b111;
    req_we    = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);

    // Reset release: two INIT edges, no grants even with all requesting.
    #1 rst_n = 1'b1;
    #1;
    check("init0_mem_rst", 32'(mem_rst), 32'd1);
    check("init0_busy", 32'(busy), 32'd1);
    check("init0_gnt", 32'(gnt), 32'd0);
    check("init0_w_en", 32'(mem_w_en), 32'd0);
    next_cycle();
    #1;
    check("init1_mem_rst", 32'(mem_rst), 32'd1);
    check("init1_busy", 32'(busy), 32'd1);
    check("init1_gnt", 32'(gnt), 32'd0);
    next_cycle();
    req = 3'b000;
    #1;
    check("run_mem_rst", 32'(mem_rst), 32'd0);
    check("run_busy", 32'(busy), 32'd0);
    check("run_idle_gnt", 32'(gnt), 32'd0);

    // Three reads from rr_ptr=0: fetch and LSU first, debug next cycle.
    next_cycle();
    set_req(0, 1'b0, 16'h0040, 16'h0);
    set_req(1, 1'b0, 16'h0041, 16'h0);
    set_req(2, 1'b0, 16'h0042, 16'h0);
    #1;
    check("rd3_gnt_a", 32'(gnt), 32'b011);
    push_exp(0, 16'h0003);
    push_exp(1, 16'h0004);
    next_cycle();
    req[0] = 1'b0;
    req[1] = 1'b0;
    #1;
    check("rd3_gnt_b", 32'(gnt), 32'b100);
    push_exp(2, 16'h0001);
    next_cycle();
    req = 3'b000;

    // Same-address write and read: read sees old data.
    set_req(1, 1'b1, 16'h003E, 16'hBEEF);
    set_req(0, 1'b0, 16'h003E, 16'h0);
    #1;
    check("rw_gnt", 32'(gnt), 32'b011);
    check("rw_w_en", 32'(mem_w_en), 32'd1);
    check("rw_w_addr", 32'(mem_w_addr), 32'h003E);
    check("rw_w_data", 32'(mem_w_data), 32'hBEEF);
    check("rw_r_addr0", 32'(mem_r_addr_0), 32'h003E);
    push_exp(0, 16'h0000);
    next_cycle();
    req = 3'b000;
    set_req(0, 1'b0, 16'h003E, 16'h0);
    #1;
    check("rw_reread_gnt", 32'(gnt), 32'b001);
    push_exp(0, 16'hBEEF);
    next_cycle();
    req = 3'b000;

    // LSU and debug hold writes: grants alternate.
    set_req(1, 1'b1, 16'h0020, 16'hA5A5);
    set_req(2, 1'b1, 16'h0021, 16'h5A5A);
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("wr_alt_gnt%0d", c), 32'(gnt), 32'(wr_gnt_tbl[c]));
      check($sformatf("wr_alt_addr%0d", c), 32'(mem_w_addr),
            (wr_gnt_tbl[c] == 3'b010) ? 32'h0020 : 32'h0021);
      next_cycle();
    end
    req = 3'b000;

    // Both read ports at once.
    set_req(0, 1'b0, 16'h0020, 16'h0);
    set_req(1, 1'b0, 16'h0021, 16'h0);
    #1;
    check("rd2_gnt", 32'(gnt), 32'b011);
    check("rd2_r_addr1", 32'(mem_r_addr_1), 32'h0021);
    push_exp(0, 16'hA5A5);
    push_exp(1, 16'h5A5A);
    next_cycle();
    req = 3'b000;

    // Full load: two reads plus one write in one cycle.
    set_req(0, 1'b0, 16'h0041, 16'h0);
    set_req(1, 1'b0, 16'h0042, 16'h0);
    set_req(2, 1'b1, 16'h0050, 16'h5555);
    #1;
    check("full_gnt", 32'(gnt), 32'b111);
    check("full_w_addr", 32'(mem_w_addr), 32'h0050);
    push_exp(0, 16'h0004);
    push_exp(1, 16'h0001);
    next_cycle();
    req = 3'b000;
    #1;
    check("idle_w_en", 32'(mem_w_en), 32'd0);
    check("idle_r_addr0", 32'(mem_r_addr_0), 32'd0);
    check("idle_w_addr", 32'(mem_w_addr), 32'd0);

    // Reset with a response pending and a write being presented.
    next_cycle();
    set_req(0, 1'b0, 16'h0040, 16'h0);
    #1;
    check("rst_pre_gnt", 32'(gnt), 32'b001);
    next_cycle();
    req = 3'b000;
    set_req(1, 1'b1, 16'h0010, 16'h1234);
    #1;
    check("rst_pending_valid", 32'(rsp_valid), 32'b001);
    rst_n = 1'b0;
    #1;
    check("rst_valid_cleared", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_mem_rst", 32'(mem_rst), 32'd1);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_w_en", 32'(mem_w_en), 32'd0);
    exp_q.delete();
    next_cycle();
    req   = 3'b000;
    rst_n = 1'b1;
    next_cycle();
    #1;
    check("reinit_busy", 32'(busy), 32'd1);
    next_cycle();
    #1;
    check("reinit_done", 32'(busy), 32'd0);

    // The aborted write must not have landed; earlier write must have.
    set_req(0, 1'b0, 16'h0010, 16'h0);
    set_req(1, 1'b0, 16'h0050, 16'h0);
    #1;
    check("post_rst_gnt", 32'(gnt), 32'b011);
    push_exp(0, 16'h0000);
    push_exp(1, 16'h5555);
    next_cycle();
    req = 3'b000;
    repeat (3) next_cycle();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
